// File: rtl/nvdla_csb_engine.sv
`timescale 1ns/1ps
// Single-outstanding command engine between a start/command port and the NVDLA CSB bus.
// Optional response timeout with sticky err_o is compiled in with `define NVDLA_CSB_TIMEOUT_EN.
module nvdla_csb_engine #(
    parameter int unsigned NPOSTED        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic        enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdat_i,
    input  logic        write_i,
    input  logic        wait_intr_i,
    output logic        csb_ready_o,
    output logic        csb_valid_o,
    output logic        csb_wr_complete_o,
    output logic        intr_o,
    output logic        err_o,
    output logic [31:0] rdata_data_o,
    output logic        rdata_valid_o,
    input  logic        rdata_ready_i,
    output logic        csb2nvdla_valid_o,
    input  logic        csb2nvdla_ready_i,
    output logic [15:0] csb2nvdla_addr_o,
    output logic [31:0] csb2nvdla_wdat_o,
    output logic        csb2nvdla_write_o,
    output logic        csb2nvdla_nposted_o,
    input  logic        nvdla2csb_valid_i,
    input  logic [31:0] nvdla2csb_data_i,
    input  logic        nvdla2csb_wr_complete_i,
    input  logic        dla_intr_i
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitRd,
        StWaitWr,
        StWaitIntr,
        StOut
    } state_e;

    localparam bit NpostedEn = (NPOSTED == 1);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        write_q, write_d;
    logic [31:0] rdata_q, rdata_d;
    logic        csb_valid_q, csb_valid_d;
    logic        wr_cpl_q, wr_cpl_d;
    logic        intr_q, intr_d;
    logic        tmo_hit;

    // CSB address is a word index: only byte-address bits [17:2] reach the bus.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:18], addr_i[1:0]};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        csb_valid_d = 1'b0;
        wr_cpl_d    = 1'b0;
        intr_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i && enable_i) begin
                    addr_d  = addr_i[17:2];
                    wdat_d  = wdat_i;
                    write_d = write_i;
                    state_d = wait_intr_i ? StWaitIntr : StReq;
                end
            end
            StReq: begin
                if (csb2nvdla_ready_i) begin
                    if (!write_q) begin
                        state_d = StWaitRd;
                    end else if (NpostedEn) begin
                        state_d = StWaitWr;
                    end else begin
                        wr_cpl_d = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            StWaitRd: begin
                if (nvdla2csb_valid_i) begin
                    rdata_d     = nvdla2csb_data_i;
                    csb_valid_d = 1'b1;
                    state_d     = StOut;
                end else if (tmo_hit) begin
                    rdata_d     = 32'hDEAD_BEEF;
                    csb_valid_d = 1'b1;
                    state_d     = StOut;
                end
            end
            StWaitWr: begin
                if (nvdla2csb_wr_complete_i || tmo_hit) begin
                    wr_cpl_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            StWaitIntr: begin
                if (dla_intr_i) begin
                    intr_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StOut: begin
                if (rdata_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (clear_i) begin
            state_d     = StIdle;
            csb_valid_d = 1'b0;
            wr_cpl_d    = 1'b0;
            intr_d      = 1'b0;
        end
    end

`ifdef NVDLA_CSB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            in_wait;
    logic            rsp_now;

    assign in_wait = (state_q == StWaitRd) || (state_q == StWaitWr);
    assign rsp_now = ((state_q == StWaitRd) && nvdla2csb_valid_i) ||
                     ((state_q == StWaitWr) && nvdla2csb_wr_complete_i);
    assign tmo_hit = in_wait && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        // Counter restarts on every entry because it is only kept while the state holds.
        if (in_wait && (state_d == state_q)) begin
            tmo_d = tmo_q + 1'b1;
        end
        err_d = !clear_i && (err_q || (tmo_hit && !rsp_now));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdat_q      <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            csb_valid_q <= 1'b0;
            wr_cpl_q    <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            csb_valid_q <= csb_valid_d;
            wr_cpl_q    <= wr_cpl_d;
            intr_q      <= intr_d;
        end
    end

    assign csb_ready_o         = (state_q == StIdle);
    assign csb_valid_o         = csb_valid_q;
    assign csb_wr_complete_o   = wr_cpl_q;
    assign intr_o              = intr_q;
    assign rdata_data_o        = rdata_q;
    assign rdata_valid_o       = (state_q == StOut);
    assign csb2nvdla_valid_o   = (state_q == StReq);
    assign csb2nvdla_addr_o    = addr_q;
    assign csb2nvdla_wdat_o    = wdat_q;
    assign csb2nvdla_write_o   = write_q;
    assign csb2nvdla_nposted_o = write_q & NpostedEn;

endmodule

// File: tb/tb_nvdla_csb_engine.sv
`timescale 1ns/1ps
// Self-checking bench for nvdla_csb_engine: directed scenarios plus randomized transactions
// checked against transaction-level expectations (word address, payload, response data queue).
module tb_nvdla_csb_engine;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst, clear, start, enable, write, wait_intr;
    logic [31:0] addr, wdat, nv_data;
    logic        rdata_ready, req_ready, nv_valid, nv_wr_cpl, dla_intr;

    logic        csb_ready, csb_valid, wr_cpl, intr, err, rdata_valid;
    logic [31:0] rdata_data, req_wdat;
    logic        req_valid, req_write, req_nposted;
    logic [15:0] req_addr;

    logic        p_csb_ready, p_csb_valid, p_wr_cpl, p_intr, p_err, p_rdata_valid;
    logic [31:0] p_rdata_data, p_req_wdat;
    logic        p_req_valid, p_req_write, p_req_nposted;
    logic [15:0] p_req_addr;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    nvdla_csb_engine #(.NPOSTED(1), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .enable_i(enable),
        .addr_i(addr), .wdat_i(wdat), .write_i(write), .wait_intr_i(wait_intr),
        .csb_ready_o(csb_ready), .csb_valid_o(csb_valid), .csb_wr_complete_o(wr_cpl),
        .intr_o(intr), .err_o(err), .rdata_data_o(rdata_data), .rdata_valid_o(rdata_valid),
        .rdata_ready_i(rdata_ready), .csb2nvdla_valid_o(req_valid),
        .csb2nvdla_ready_i(req_ready), .csb2nvdla_addr_o(req_addr),
        .csb2nvdla_wdat_o(req_wdat), .csb2nvdla_write_o(req_write),
        .csb2nvdla_nposted_o(req_nposted), .nvdla2csb_valid_i(nv_valid),
        .nvdla2csb_data_i(nv_data), .nvdla2csb_wr_complete_i(nv_wr_cpl), .dla_intr_i(dla_intr)
    );

    nvdla_csb_engine #(.NPOSTED(0), .TIMEOUT_CYCLES(TMO)) u_dut_p (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .enable_i(enable),
        .addr_i(addr), .wdat_i(wdat), .write_i(write), .wait_intr_i(wait_intr),
        .csb_ready_o(p_csb_ready), .csb_valid_o(p_csb_valid), .csb_wr_complete_o(p_wr_cpl),
        .intr_o(p_intr), .err_o(p_err), .rdata_data_o(p_rdata_data),
        .rdata_valid_o(p_rdata_valid), .rdata_ready_i(rdata_ready),
        .csb2nvdla_valid_o(p_req_valid), .csb2nvdla_ready_i(req_ready),
        .csb2nvdla_addr_o(p_req_addr), .csb2nvdla_wdat_o(p_req_wdat),
        .csb2nvdla_write_o(p_req_write), .csb2nvdla_nposted_o(p_req_nposted),
        .nvdla2csb_valid_i(nv_valid), .nvdla2csb_data_i(nv_data),
        .nvdla2csb_wr_complete_i(nv_wr_cpl), .dla_intr_i(dla_intr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic wr,
                         input logic wi);
        start = 1'b1; enable = 1'b1; addr = a; wdat = d; write = wr; wait_intr = wi;
        step();
        // Scramble command inputs after acceptance; the engine must hold its copy.
        start = 1'b0; enable = 1'($urandom_range(1));
        addr = $urandom; wdat = $urandom; write = 1'($urandom_range(1));
        wait_intr = 1'($urandom_range(1));
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 0; start = 0; enable = 0; addr = 0; wdat = 0; write = 0;
        wait_intr = 0; rdata_ready = 0; req_ready = 0; nv_valid = 0; nv_data = 0;
        nv_wr_cpl = 0; dla_intr = 0;
        step();
        checks++;
        if ({csb_ready, csb_valid, wr_cpl, intr, err, rdata_valid, req_valid, req_write,
             req_nposted} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 100000000", {csb_ready, csb_valid, wr_cpl,
                     intr, err, rdata_valid, req_valid, req_write, req_nposted});
        end
        checks++;
        if ({rdata_data, req_addr, req_wdat} !== 80'h0) begin
            errors++;
            $display("FAIL reset_data: got %h exp 0", {rdata_data, req_addr, req_wdat});
        end
        checks++;
        if ({p_csb_ready, p_csb_valid, p_wr_cpl, p_intr, p_err, p_rdata_valid, p_req_valid,
             p_req_write, p_req_nposted, p_rdata_data, p_req_addr, p_req_wdat}
            !== {9'b1_0000_0000, 80'h0}) begin
            errors++;
            $display("FAIL reset_posted: ready=%b valid=%b got nonzero outputs", p_csb_ready,
                     p_req_valid);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int unsigned rdly,
                           input int unsigned sdly, input int unsigned hold);
        logic [15:0] ea;
        logic [31:0] ed;
        ea = 16'(a >> 2);
        issue(a, $urandom, 1'b0, 1'b0);
        for (int k = 0; k <= int'(rdly); k++) begin
            if (k == int'(rdly)) begin
                req_ready = 1'b1;
                nv_valid  = 1'($urandom_range(1));
                nv_data   = $urandom;
            end
            checks++;
            if ({req_valid, req_addr, req_write, req_nposted} !== {1'b1, ea, 2'b00}) begin
                errors++;
                $display("FAIL rd_req: got v=%b a=%h w=%b np=%b exp v=1 a=%h w=0 np=0",
                         req_valid, req_addr, req_write, req_nposted, ea);
            end
            step();
        end
        req_ready = 1'b0; nv_valid = 1'b0;
        for (int k = 0; k < int'(sdly); k++) begin
            checks++;
            if ({req_valid, csb_valid, rdata_valid, csb_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL rd_wait: got %b exp 0000",
                         {req_valid, csb_valid, rdata_valid, csb_ready});
            end
            step();
        end
        nv_valid = 1'b1; nv_data = d; exp_q.push_back(d);
        step();
        nv_valid = 1'b0; nv_data = $urandom;
        ed = exp_q.pop_front();
        checks++;
        if ({csb_valid, rdata_valid, rdata_data, csb_ready} !== {2'b11, ed, 1'b0}) begin
            errors++;
            $display("FAIL rd_data: got cv=%b rv=%b d=%h r=%b exp cv=1 rv=1 d=%h r=0",
                     csb_valid, rdata_valid, rdata_data, csb_ready, ed);
        end
        for (int k = 0; k < int'(hold); k++) begin
            nv_valid = 1'($urandom_range(1)); nv_data = $urandom;
            step();
            checks++;
            if ({csb_valid, rdata_valid, rdata_data} !== {2'b01, ed}) begin
                errors++;
                $display("FAIL rd_hold: got cv=%b rv=%b d=%h exp cv=0 rv=1 d=%h",
                         csb_valid, rdata_valid, rdata_data, ed);
            end
        end
        nv_valid = 1'b0; rdata_ready = 1'b1;
        step();
        rdata_ready = 1'b0;
        checks++;
        if ({rdata_valid, csb_ready, csb_valid} !== 3'b010) begin
            errors++;
            $display("FAIL rd_done: got %b exp 010", {rdata_valid, csb_ready, csb_valid});
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int unsigned rdly,
                            input int unsigned sdly);
        logic [15:0] ea;
        ea = 16'(a >> 2);
        issue(a, d, 1'b1, 1'b0);
        for (int k = 0; k <= int'(rdly); k++) begin
            if (k == int'(rdly)) begin
                req_ready = 1'b1;
                nv_wr_cpl = 1'($urandom_range(1));
            end
            checks++;
            if ({req_valid, req_addr, req_wdat, req_write, req_nposted} !== {1'b1, ea, d, 2'b11})
            begin
                errors++;
                $display("FAIL wr_req: got v=%b a=%h d=%h w=%b np=%b exp v=1 a=%h d=%h w=1 np=1",
                         req_valid, req_addr, req_wdat, req_write, req_nposted, ea, d);
            end
            step();
        end
        req_ready = 1'b0; nv_wr_cpl = 1'b0;
        for (int k = 0; k < int'(sdly); k++) begin
            checks++;
            if ({wr_cpl, csb_ready, req_valid} !== 3'b000) begin
                errors++;
                $display("FAIL wr_wait: got %b exp 000", {wr_cpl, csb_ready, req_valid});
            end
            step();
        end
        nv_wr_cpl = 1'b1;
        step();
        nv_wr_cpl = 1'b0;
        checks++;
        if ({wr_cpl, csb_ready} !== 2'b11) begin
            errors++;
            $display("FAIL wr_cpl: got %b exp 11", {wr_cpl, csb_ready});
        end
        step();
        checks++;
        if ({wr_cpl, csb_ready} !== 2'b01) begin
            errors++;
            $display("FAIL wr_cpl_once: got %b exp 01", {wr_cpl, csb_ready});
        end
    endtask

    task automatic do_intr(input logic wr, input logic pre, input int unsigned dly);
        dla_intr = pre;
        issue($urandom, $urandom, wr, 1'b1);
        checks++;
        if ({req_valid, csb_ready, intr} !== 3'b000) begin
            errors++;
            $display("FAIL intr_enter: got %b exp 000", {req_valid, csb_ready, intr});
        end
        if (!pre) begin
            for (int k = 0; k < int'(dly); k++) begin
                step();
                checks++;
                if ({req_valid, csb_ready, intr} !== 3'b000) begin
                    errors++;
                    $display("FAIL intr_wait: got %b exp 000", {req_valid, csb_ready, intr});
                end
            end
            dla_intr = 1'b1;
        end
        step();
        checks++;
        if ({intr, csb_ready, req_valid} !== 3'b110) begin
            errors++;
            $display("FAIL intr_pulse: got %b exp 110", {intr, csb_ready, req_valid});
        end
        step();
        dla_intr = 1'b0;
        checks++;
        if ({intr, csb_ready} !== 2'b01) begin
            errors++;
            $display("FAIL intr_once: got %b exp 01", {intr, csb_ready});
        end
    endtask

    task automatic test_read();
        do_read(32'h0000_5004, 32'hCAFE_0001, 0, 1, 2);
    endtask

    task automatic test_write();
        do_write($urandom, 32'h1234_5678, 3, 2);
    endtask

    task automatic test_intr();
        do_intr(1'b1, 1'b0, 5);
        do_intr(1'b0, 1'b1, 0);
    endtask

    task automatic test_enable();
        start = 1'b1; enable = 1'b0; addr = $urandom; write = 1'b0; wait_intr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({csb_ready, req_valid, csb_valid, wr_cpl, intr} !== 5'b10000) begin
                errors++;
                $display("FAIL enable_gate: got %b exp 10000",
                         {csb_ready, req_valid, csb_valid, wr_cpl, intr});
            end
        end
        start = 1'b0;
    endtask

    task automatic test_spurious();
        for (int k = 0; k < 4; k++) begin
            nv_valid = 1'b1; nv_wr_cpl = 1'b1; dla_intr = 1'b1; nv_data = $urandom;
            step();
            checks++;
            if ({csb_valid, wr_cpl, intr, csb_ready, rdata_valid} !== 5'b00010) begin
                errors++;
                $display("FAIL spurious_idle: got %b exp 00010",
                         {csb_valid, wr_cpl, intr, csb_ready, rdata_valid});
            end
        end
        nv_valid = 1'b0; nv_wr_cpl = 1'b0; dla_intr = 1'b0;
    endtask

    task automatic test_clear();
        issue($urandom, 0, 1'b0, 1'b0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({csb_ready, req_valid, rdata_valid, err, csb_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL clear_wait_rd: got %b exp 10000",
                     {csb_ready, req_valid, rdata_valid, err, csb_valid});
        end
        nv_valid = 1'b1; nv_data = $urandom;
        step();
        nv_valid = 1'b0;
        checks++;
        if ({csb_valid, csb_ready} !== 2'b01) begin
            errors++;
            $display("FAIL clear_late_rsp: got %b exp 01", {csb_valid, csb_ready});
        end
        issue($urandom, 0, 1'b0, 1'b0);
        pulse_clear();
        checks++;
        if ({req_valid, csb_ready} !== 2'b01) begin
            errors++;
            $display("FAIL clear_req: got %b exp 01", {req_valid, csb_ready});
        end
        issue($urandom, 0, 1'b0, 1'b0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0; nv_valid = 1'b1; nv_data = $urandom;
        step();
        nv_valid = 1'b0;
        pulse_clear();
        checks++;
        if ({rdata_valid, csb_ready} !== 2'b01) begin
            errors++;
            $display("FAIL clear_out: got %b exp 01", {rdata_valid, csb_ready});
        end
        clear = 1'b1; start = 1'b1; enable = 1'b1; write = 1'b0; wait_intr = 1'b0;
        step();
        clear = 1'b0; start = 1'b0;
        checks++;
        if ({csb_ready, req_valid} !== 2'b10) begin
            errors++;
            $display("FAIL clear_over_start: got %b exp 10", {csb_ready, req_valid});
        end
    endtask

    task automatic test_reset_mid();
        issue($urandom, 0, 1'b0, 1'b0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0; nv_valid = 1'b1; nv_data = 32'hA5A5_0F0F;
        step();
        nv_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rdata_valid, csb_ready, rdata_data} !== {2'b01, 32'h0}) begin
            errors++;
            $display("FAIL reset_in_out: got rv=%b r=%b d=%h exp rv=0 r=1 d=0",
                     rdata_valid, csb_ready, rdata_data);
        end
        step();
        rst = 1'b0;
        step();
        issue($urandom, $urandom, 1'b1, 1'b0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; nv_wr_cpl = 1'b1; nv_valid = 1'b1;
        step();
        nv_wr_cpl = 1'b0; nv_valid = 1'b0;
        checks++;
        if ({wr_cpl, csb_valid, csb_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_in_wait_wr: got %b exp 001", {wr_cpl, csb_valid, csb_ready});
        end
    endtask

    task automatic test_posted();
        logic [31:0] d;
        d = $urandom;
        pulse_clear();
        issue(32'h0003_FFFC, d, 1'b1, 1'b0);
        checks++;
        if ({p_req_valid, p_req_write, p_req_nposted, p_req_wdat, p_req_addr}
            !== {3'b110, d, 16'hFFFF}) begin
            errors++;
            $display("FAIL posted_req: got v=%b w=%b np=%b d=%h a=%h exp v=1 w=1 np=0 d=%h a=ffff",
                     p_req_valid, p_req_write, p_req_nposted, p_req_wdat, p_req_addr, d);
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        checks++;
        if ({p_wr_cpl, p_csb_ready, p_req_valid} !== 3'b110) begin
            errors++;
            $display("FAIL posted_cpl: got %b exp 110", {p_wr_cpl, p_csb_ready, p_req_valid});
        end
        step();
        checks++;
        if ({p_wr_cpl, p_csb_ready} !== 2'b01) begin
            errors++;
            $display("FAIL posted_once: got %b exp 01", {p_wr_cpl, p_csb_ready});
        end
        pulse_clear();
    endtask

    task automatic test_timeout();
        logic seen;
        seen = 1'b0;
        issue($urandom, 0, 1'b0, 1'b0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
`ifdef NVDLA_CSB_TIMEOUT_EN
        for (int k = 0; k < int'(TMO); k++) begin
            seen = seen | csb_valid | err | rdata_valid;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early: got %b exp 0", seen);
        end
        checks++;
        if ({csb_valid, err, rdata_valid, rdata_data} !== {3'b111, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL tmo_rd: got cv=%b e=%b rv=%b d=%h exp cv=1 e=1 rv=1 d=deadbeef",
                     csb_valid, err, rdata_valid, rdata_data);
        end
        rdata_ready = 1'b1;
        step();
        rdata_ready = 1'b0;
        issue($urandom, $urandom, 1'b1, 1'b0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        for (int k = 0; k < int'(TMO); k++) begin
            seen = seen | wr_cpl | csb_ready;
            step();
        end
        checks++;
        if ({seen, wr_cpl, csb_ready, err} !== 4'b0111) begin
            errors++;
            $display("FAIL tmo_wr: got %b exp 0111", {seen, wr_cpl, csb_ready, err});
        end
        pulse_clear();
        checks++;
        if ({err, csb_ready} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_clear: got %b exp 01", {err, csb_ready});
        end
`else
        for (int k = 0; k < 100; k++) begin
            step();
            seen = seen | csb_valid | rdata_valid | csb_ready | err;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL no_tmo_rd: got %b exp 0", seen);
        end
        pulse_clear();
        issue($urandom, $urandom, 1'b1, 1'b0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            seen = seen | wr_cpl | csb_ready | err;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL no_tmo_wr: got %b exp 0", seen);
        end
        pulse_clear();
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(2))
                0: do_read($urandom, $urandom, $urandom_range(3), $urandom_range(5),
                           $urandom_range(3));
                1: do_write($urandom, $urandom, $urandom_range(3), $urandom_range(5));
                default: do_intr(1'($urandom_range(1)), 1'($urandom_range(1)),
                                 $urandom_range(4));
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_intr();
        test_enable();
        test_spurious();
        test_clear();
        test_reset_mid();
        test_posted();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
